// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state enum, requester ids and defaults
// for the two-requester RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } arb_state_t;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_CORE   = 1'b1;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/ram_arb_timeout_cnt.sv
// ram_arb_timeout_cnt: clearable saturating response-wait counter
// for the RAM port arbiter.
module ram_arb_timeout_cnt #(
  parameter int W = 5
) (
  input  logic         clk_sys,
  input  logic         rst_sys,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: boot loader / core arbiter for one RAM port.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin, else m0 has priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_lock,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic                m0_err,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic                m1_err,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_rvalid,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic             owner;
  logic             gap;
  logic [CNT_W-1:0] cnt;
  logic             m1_elig;
  logic             any_req;
  logic             win;
  logic             issue;
  logic             rsp;
  logic             err;
  logic [DATA_W-1:0] rsp_data;

  assign m1_elig = m1_req & ~m0_lock;
  assign any_req = m0_req | m1_elig;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic rr_ptr;
  assign win = m1_elig & (~m0_req | rr_ptr);
`else
  assign win = m1_elig & ~m0_req;
`endif

  // gap holds off a grant for one cycle after every response
  assign issue = (state == IDLE) & ~gap & any_req & ~rst_sys;
  assign rsp   = (state == WAIT_RSP) & (ram_rvalid | (cnt == LAST));
  assign err   = rsp & ~ram_rvalid;

  assign rsp_data = (rsp & ram_rvalid) ? ram_rdata : '0;

  assign m0_gnt    = issue & (win == REQ_LOADER);
  assign m1_gnt    = issue & (win == REQ_CORE);
  assign ram_req   = issue;
  assign ram_we    = issue & (win ? m1_we : m0_we);
  assign ram_addr  = issue ? (win ? m1_addr : m0_addr) : '0;
  assign ram_be    = issue ? (win ? m1_be : m0_be) : '0;
  assign ram_wdata = issue ? (win ? m1_wdata : m0_wdata) : '0;

  assign m0_rvalid = rsp & (owner == REQ_LOADER);
  assign m1_rvalid = rsp & (owner == REQ_CORE);
  assign m0_err    = err & (owner == REQ_LOADER);
  assign m1_err    = err & (owner == REQ_CORE);
  assign m0_rdata  = m0_rvalid ? rsp_data : '0;
  assign m1_rdata  = m1_rvalid ? rsp_data : '0;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state  <= IDLE;
      owner  <= REQ_LOADER;
      gap    <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      rr_ptr <= REQ_LOADER;
`endif
    end else begin
      gap <= rsp;
      unique case (state)
        IDLE: begin
          if (issue) begin
            state  <= WAIT_RSP;
            owner  <= win;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            rr_ptr <= ~win;
`endif
          end
        end
        WAIT_RSP: begin
          if (rsp) state <= IDLE;
        end
      endcase
    end
  end

  ram_arb_timeout_cnt #(
    .W (CNT_W)
  ) u_tmo (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .clr     (issue),
    .inc     (state == WAIT_RSP),
    .cnt     (cnt)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with a cycle-level
// transaction model checked on every falling edge.
module tb_ram_port_arbiter;

  localparam int TMO = 16;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_be;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_be;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ram_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_be      (m0_be),
    .m0_wdata   (m0_wdata),
    .m0_lock    (m0_lock),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_err     (m0_err),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_be      (m1_be),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_err     (m1_err),
    .m1_rdata   (m1_rdata),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_rvalid (ram_rvalid),
    .ram_rdata  (ram_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: busy/owner, cycle of grant, cycle of last response
  int cyc = 0;
  bit busy = 0;
  bit own = 0;
  bit ptr = 0;
  int gcyc = 0;
  int lrsp = -10;

  always @(negedge clk_sys) begin : cmp
    logic e_g0, e_g1, e_rq, e_we, e_v0, e_v1, e_e0, e_e1;
    logic [31:0] e_ad, e_wd, e_d0, e_d1;
    logic [3:0] e_be;
    logic el0, el1, w;
    cyc++;
    {e_g0, e_g1, e_rq, e_we, e_v0, e_v1, e_e0, e_e1} = '0;
    e_ad = '0; e_wd = '0; e_be = '0; e_d0 = '0; e_d1 = '0;
    if (rst_sys) begin
      busy = 0; own = 0; ptr = 0; lrsp = -10;
    end else if (busy) begin
      if (ram_rvalid || (cyc - gcyc == TMO)) begin
        if (own) begin
          e_v1 = 1; e_e1 = !ram_rvalid;
          e_d1 = ram_rvalid ? ram_rdata : 32'h0;
        end else begin
          e_v0 = 1; e_e0 = !ram_rvalid;
          e_d0 = ram_rvalid ? ram_rdata : 32'h0;
        end
        busy = 0;
        lrsp = cyc;
      end
    end else if (cyc - lrsp >= 2) begin
      el0 = m0_req;
      el1 = m1_req && !m0_lock;
      if (el0 || el1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        w = (el0 && el1) ? ptr : el1;
`else
        w = !el0;
`endif
        e_g0 = !w; e_g1 = w; e_rq = 1;
        e_we = w ? m1_we : m0_we;
        e_ad = w ? m1_addr : m0_addr;
        e_be = w ? m1_be : m0_be;
        e_wd = w ? m1_wdata : m0_wdata;
        busy = 1; own = w; gcyc = cyc; ptr = !w;
      end
    end
    chk("m0_gnt", 64'(m0_gnt), 64'(e_g0));
    chk("m1_gnt", 64'(m1_gnt), 64'(e_g1));
    chk("ram_req", 64'(ram_req), 64'(e_rq));
    chk("ram_we", 64'(ram_we), 64'(e_we));
    chk("ram_addr", 64'(ram_addr), 64'(e_ad));
    chk("ram_be", 64'(ram_be), 64'(e_be));
    chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(e_v0));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(e_v1));
    chk("m0_err", 64'(m0_err), 64'(e_e0));
    chk("m1_err", 64'(m1_err), 64'(e_e1));
    chk("m0_rdata", 64'(m0_rdata), 64'(e_d0));
    chk("m1_rdata", 64'(m1_rdata), 64'(e_d1));
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  bit gseq[$];
  int n0, n1, k;
  bit exp_first;

  initial begin
    rst_sys = 1; m0_lock = 0; ram_rvalid = 0; ram_rdata = '0;
    m0_req = 1; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h0010_0004;
    m1_be = 4'hF; m1_wdata = 32'h5555_AAAA;
    repeat (2) step();
    #1;
    chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
    chk("rst_ram_req", 64'(ram_req), 64'd0);
    step(); rst_sys = 0; m0_req = 0; m1_req = 0;

    // single m0 write
    step();
    m0_req = 1; m0_we = 1; m0_addr = 32'h0010_0000;
    m0_wdata = 32'hDEAD_BEEF; m0_be = 4'hF;
    #1;
    chk("wr_gnt", 64'(m0_gnt), 64'd1);
    chk("wr_addr", 64'(ram_addr), 64'h0010_0000);
    chk("wr_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    chk("wr_be", 64'(ram_be), 64'hF);
    chk("wr_we", 64'(ram_we), 64'd1);
    step(); m0_req = 0; m0_we = 0; ram_rvalid = 1;
    ram_rdata = 32'h1234_5678;
    #1;
    chk("wr_rvalid", 64'(m0_rvalid), 64'd1);
    chk("wr_err", 64'(m0_err), 64'd0);
    chk("wr_m1_rvalid", 64'(m1_rvalid), 64'd0);
    step(); ram_rvalid = 0;

    // both requesting, RAM answers one cycle after grant
    step(); m0_req = 1; m1_req = 1; ram_rvalid = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      #1;
      if (m0_gnt) gseq.push_back(1'b0);
      if (m1_gnt) gseq.push_back(1'b1);
    end
    chk("arb_count", 64'(gseq.size()), 64'd4);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_first = 1'b1;
    for (int i = 0; i < gseq.size(); i++)
      chk("arb_seq", 64'(gseq[i]), 64'(exp_first ^ i[0]));
`else
    exp_first = 1'b0;
    for (int i = 0; i < gseq.size(); i++)
      chk("arb_seq", 64'(gseq[i]), 64'(exp_first));
`endif

    // lock keeps m1 out for ten m0 transactions
    step(); m0_lock = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) step();
      #1;
      n0 += int'(m0_gnt);
      n1 += int'(m1_gnt);
    end
    chk("lock_m0_grants", 64'(n0), 64'd10);
    chk("lock_m1_grants", 64'(n1), 64'd0);
    step(); m0_lock = 0; m0_req = 0;
    #1;
    chk("unlock_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("unlock_addr", 64'(ram_addr), 64'h0010_0004);
    step(); m1_req = 0;
    #1;
    chk("unlock_rvalid", 64'(m1_rvalid), 64'd1);
    step(); ram_rvalid = 0;

    // m1 read that never gets an answer
    step(); m1_req = 1; m1_we = 0;
    #1;
    chk("tmo_gnt", 64'(m1_gnt), 64'd1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step(); m1_req = 0;
      #1;
      if (m1_rvalid) begin
        k = i;
        break;
      end
    end
    chk("tmo_latency", 64'(k), 64'd16);
    chk("tmo_err", 64'(m1_err), 64'd1);
    chk("tmo_rdata", 64'(m1_rdata), 64'd0);
    step(); ram_rvalid = 1; ram_rdata = 32'hBADB_AD00;
    #1;
    chk("stray_m1", 64'(m1_rvalid), 64'd0);
    chk("stray_m0", 64'(m0_rvalid), 64'd0);
    step(); ram_rvalid = 0;

    // answer lands on the last timeout cycle
    step(); m0_req = 1; m0_addr = 32'h0010_0008;
    #1;
    chk("edge_gnt", 64'(m0_gnt), 64'd1);
    repeat (15) begin
      step(); m0_req = 0;
    end
    step(); ram_rvalid = 1; ram_rdata = 32'hCAFE_F00D;
    #1;
    chk("edge_rvalid", 64'(m0_rvalid), 64'd1);
    chk("edge_err", 64'(m0_err), 64'd0);
    chk("edge_rdata", 64'(m0_rdata), 64'hCAFE_F00D);
    step(); ram_rvalid = 0;

    // reset while waiting on a response
    step(); m1_req = 1;
    #1;
    chk("rw_gnt", 64'(m1_gnt), 64'd1);
    step(); m1_req = 0;
    step(); rst_sys = 1;
    #1;
    chk("rw_rst_req", 64'(ram_req), 64'd0);
    step(); rst_sys = 0;
    step(); ram_rvalid = 1; ram_rdata = 32'h1111_2222;
    #1;
    chk("rw_late_m1", 64'(m1_rvalid), 64'd0);
    chk("rw_late_m0", 64'(m0_rvalid), 64'd0);
    step(); ram_rvalid = 0; m1_req = 1;
    #1;
    chk("rw_regnt", 64'(m1_gnt), 64'd1);
    step(); m1_req = 0; ram_rvalid = 1; ram_rdata = 32'h0BAD_F00D;
    #1;
    chk("rw_rvalid", 64'(m1_rvalid), 64'd1);
    chk("rw_rdata", 64'(m1_rdata), 64'h0BAD_F00D);
    step(); ram_rvalid = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
